// File: rtl/cm_sched_wrr.sv
// Weighted round-robin packet scheduler; grant held from first beat to last-beat handshake.
// Latency: grant one cycle after an eligible request in IDLE; o_ack is combinational from i_req/i_rdy.
// Backpressure: i_rdy=0 stalls the granted packet without releasing it. Optional watchdog: CM_SCHED_WRR_WDOG_EN.
module cm_sched_wrr #(
  parameter int DCNT      = 4,
  parameter int WWIDTH    = 4,
  parameter int WDOG_CNT  = 16,
  localparam int IDX_WIDTH = $clog2(DCNT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DCNT-1:0]        i_req,
  input  logic [DCNT-1:0]        i_last,
  input  logic [DCNT*WWIDTH-1:0] i_weight,
  input  logic                   i_rdy,
  output logic                   o_gnt_vld,
  output logic [IDX_WIDTH-1:0]   o_gnt,
  output logic [DCNT-1:0]        o_gnt_oh,
  output logic [DCNT-1:0]        o_ack,
  output logic                   o_wdog
);

  typedef enum logic [1:0] {IDLE, REFILL, GRANT} state_t;

  state_t               state, state_n;
  logic [WWIDTH-1:0]    cred [DCNT];
  logic [IDX_WIDTH-1:0] ptr;
  logic [DCNT-1:0]      elig;
  logic                 any_ref;
  logic                 sel_vld;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic                 load, refill, done;
  logic                 wdog_hit;

  always_comb begin
    elig    = '0;
    any_ref = 1'b0;
    for (int i = 0; i < DCNT; i++) begin
      elig[i] = i_req[i] && (cred[i] != '0);
      any_ref = any_ref | (i_req[i] && (i_weight[i*WWIDTH +: WWIDTH] != '0));
    end
  end

  // Walk the search order backwards so the nearest index after ptr wins.
  always_comb begin : sel_p
    int j;
    j       = 0;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = DCNT; k >= 1; k--) begin
      j = (int'(ptr) + k) % DCNT;
      if (elig[j]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_WIDTH'(j);
      end
    end
  end

`ifdef CM_SCHED_WRR_WDOG_EN
  localparam int WDW = $clog2(WDOG_CNT + 1);
  logic [WDW-1:0] wcnt;

  assign wdog_hit = (state == GRANT) && !i_req[o_gnt] && i_rdy && (wcnt == WDW'(WDOG_CNT - 1));
  assign o_wdog   = wdog_hit;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                   wcnt <= '0;
    else if (state != GRANT || i_req[o_gnt] || wdog_hit) wcnt <= '0;
    else if (i_rdy)                               wcnt <= wcnt + 1'b1;
  end
`else
  localparam int unused_wdog_cnt = WDOG_CNT;
  assign wdog_hit = 1'b0;
  assign o_wdog   = 1'b0;
`endif

  assign o_gnt_vld = (state == GRANT);

  always_comb begin
    o_gnt_oh = '0;
    o_ack    = '0;
    if (o_gnt_vld) begin
      o_gnt_oh[o_gnt] = 1'b1;
      o_ack[o_gnt]    = i_req[o_gnt] && i_rdy;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    refill  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_n = GRANT;
          load    = 1'b1;
        end else if (any_ref) begin
          state_n = REFILL;
        end
      end
      REFILL: begin
        refill  = 1'b1;
        state_n = IDLE;
      end
      GRANT: begin
        if ((i_req[o_gnt] && i_rdy && i_last[o_gnt]) || wdog_hit) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      ptr   <= IDX_WIDTH'(DCNT - 1);
      o_gnt <= '0;
      for (int i = 0; i < DCNT; i++) cred[i] <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        o_gnt <= sel_idx;
        ptr   <= sel_idx;
      end
      for (int i = 0; i < DCNT; i++) begin
        if (refill)
          cred[i] <= i_weight[i*WWIDTH +: WWIDTH];
        else if (done && (o_gnt == IDX_WIDTH'(i)) && (cred[i] != '0))
          cred[i] <= cred[i] - 1'b1;
      end
    end
  end

endmodule

// File: doc/cm_sched_wrr.md
Name: cm_sched_wrr

Overview:
- Weighted round-robin scheduler that shares one downstream resource, such as a sort/compare pipeline or an output port, between DCNT packet requesters.
- Each requester receives up to i_weight[i] packets per round. A grant is locked for the whole packet, from its first beat until its last-beat handshake.
- Sits in lib_cm, in front of the shared datapath. It drives the requester index used as the datapath mux select.

Parameters:
- DCNT, 4, requester count (≥2).
- WWIDTH, 4, weight/credit width.
- WDOG_CNT, 16, watchdog limit in cycles; used only with the optional feature.
- IDX_WIDTH, localparam sclog2(DCNT), grant index width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-low reset.
- i_req  in  DCNT  per-requester beat valid.
- i_last  in  DCNT  per-requester last beat of packet.
- i_weight  in  DCNT×WWIDTH  packets per round; 0 = requester never granted.
- i_rdy  in  1  shared resource ready.
- o_gnt_vld  out  1  grant active.
- o_gnt  out  IDX_WIDTH  granted index.
- o_gnt_oh  out  DCNT  one-hot grant; zero when o_gnt_vld=0.
- o_ack  out  DCNT  beat accepted (combinational).
- o_wdog  out  1  watchdog release pulse.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - state=IDLE, all credits cred[i]=0, pointer ptr=DCNT-1.
  - Outputs: o_gnt_vld=0, o_gnt=0, o_gnt_oh=0, o_wdog=0.
  - Reset asserted mid-packet aborts the grant immediately. No credit is decremented.
- Eligibility: eligible[i] = i_req[i] && cred[i]!=0.
- Selection: first eligible index in the order ptr+1, ptr+2, …, ptr (mod DCNT).
- FSM states: IDLE, REFILL, GRANT.
  - IDLE, some index eligible: load o_gnt = selected index, ptr = selected index, go to GRANT. o_gnt_vld=1 from the next cycle.
  - IDLE, none eligible, but some i with i_req[i] && i_weight[i]!=0: go to REFILL.
  - IDLE, otherwise: stay in IDLE.
  - REFILL (one cycle): cred[i] = i_weight[i] for every i, sampled this cycle; go to IDLE.
  - GRANT: o_ack[g] = i_req[g] && i_rdy; all other o_ack bits are 0. On o_ack[g] && i_last[g]: cred[g] decrements by 1 (saturating at 0) and state returns to IDLE.
- Latency:
  - Steady state: one IDLE bubble cycle between packets. A request seen in IDLE produces o_gnt_vld on the next cycle.
  - After reset: first grant appears 3 edges after i_req rises (IDLE→REFILL→IDLE→GRANT).
- Grant lock: o_gnt is stable for the whole packet. Requests from other indices, i_weight changes, and i_rdy stalls do not affect it.
- Single-beat packet: a beat with i_last=1 and o_ack=1 on the first grant cycle completes the packet.
- Weight handling:
  - Weight 0 (after refill) excludes that requester for the round.
  - If every requester is at weight 0, the block stays in IDLE and never grants.
  - Weight changes take effect only at the next REFILL.
- Credits are per round. A requester with credit left but no request does not block refill; refill occurs only when no requester is eligible.
- Wrap-around: after a grant to index DCNT-1, the search starts at index 0.

Optional Feature:
- Macro CM_SCHED_WRR_WDOG_EN.
- Defined:
  - A counter (width sclog2(WDOG_CNT+1)) counts consecutive GRANT cycles with i_req[g]=0. It clears on any cycle with i_req[g]=1 and on entry to GRANT.
  - When the count reaches WDOG_CNT: the grant is released (state→IDLE), cred[g] decrements, and o_wdog pulses high for one cycle.
  - i_rdy=0 stalls do not count.
- Not defined: o_wdog is tied to 0, no counter exists, and a granted requester that drops i_req holds the grant indefinitely.

Test Plan:
1. Reset, weights {1,1,1,1}, all i_req=1 continuously, i_last=1, i_rdy=1:
   - First o_gnt_vld 3 cycles after reset release.
   - Grants appear in order 0,1,2,3, each 1 cycle with 1 bubble between.
   - REFILL occurs after grant 3, then the sequence repeats from 0.
2. Weights {2,1,0,1}, all requesting, single-beat packets:
   - Per round, grant sequence 0,1,3,0.
   - Index 2 is never granted.
   - o_gnt_oh matches o_gnt on every grant cycle.
3. Requester 1 sends a 4-beat packet with i_rdy low on beats 2 and 3 for 2 cycles each:
   - o_gnt=1 is held for 8 cycles.
   - o_ack[1] pulses exactly 4 times.
   - Requester 0 is held off despite i_req[0]=1.
4. i_rst driven low mid-packet while granted to 2:
   - o_gnt_vld, o_gnt_oh and o_ack go to 0 asynchronously, before the next clock edge.
   - After release, arbitration restarts at index 0 via REFILL.
5. All weights 0, all requesting, for 50 cycles: o_gnt_vld stays 0 and the state never leaves IDLE.
6. With CM_SCHED_WRR_WDOG_EN, WDOG_CNT=16: granted requester 3 drops i_req after beat 1.
   - o_wdog pulses once on the 16th idle cycle.
   - The next grant goes to the next eligible index.
   - Without the macro, o_gnt stays 3 for 100 cycles.
